dev_uart_tx: RTL and testbench
==============================

# dev_uart_tx

Asynchronous UART transmitter, the sending end of our `dev_uart_rx` link. It accepts bytes on a one-clock strobe into a small internal FIFO and serialises each one onto `TxD` as an 8N1 frame: start bit, 8 data bits LSB first, optional parity, stop bit. It is paced by the same `TIC` strobe as the receiver, at 8x the baud rate, so a paired TX/RX share one tick generator.

## Interface
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, 2..16.
- `CLK` input 1: clock.
- `RST` input 1: reset, synchronous, active-high.
- `TIC` input 1: one-clock tick at 8x the baud rate, e.g. 115200*8 Hz.
- `TxDAT` input 8: byte to send.
- `TxSTB` input 1: write strobe; one clock per byte.
- `TxD` output 1: serial line to the pad, registered; idles high.
- `TxFULL` output 1: FIFO full; a `TxSTB` while this is high is dropped.
- `TxEMPTY` output 1: FIFO holds no bytes.
- `TxBUSY` output 1: a frame is in progress; high from the start-bit edge until the stop bit ends.
- `TxOVF` output 1: one-clock pulse when a `TxSTB` is dropped.

## Operation
- **Reset.** On `RST`: `TxD`=1, `TxBUSY`=0, `TxFULL`=0, `TxEMPTY`=1, `TxOVF`=0, FIFO pointers and count cleared, FSM in IDLE.
- **Reset mid-frame.** The frame is abandoned: `TxD` returns high on that edge and buffered bytes are lost.
- **FIFO push.**
  - `TxSTB` with `TxFULL`=0 writes `TxDAT` at the clock edge.
  - `TxSTB` with `TxFULL`=1 is dropped and pulses `TxOVF` on the next cycle.
- **FIFO pop.** Happens only on a start-bit load.
- **Simultaneous push and pop.** Both occur and the count is unchanged. A push on a full FIFO is dropped even if a pop happens in the same cycle; acceptance uses the registered `TxFULL`.
- **Count.** The FIFO count is `clog2(FIFO_DEPTH)+1` bits. Read and write pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, START, DATA, PARITY (only when compiled in), STOP.
- **Per-state tick counter.** `tcnt` is 3 bits. It is loaded with 7 when a bit begins and decremented on each `TIC`; `TIC` on `tcnt`=0 ends the bit. Every bit therefore lasts exactly 8 `TIC`s.
- **IDLE.** On `TIC` with the FIFO non-empty: pop into the shift register, drive `TxD`=0, go to START, set `TxBUSY`=1.
- **START → DATA.** Drive `TxD`=shift[0]. The bit index counts 0..7, and the register shifts right at each bit end.
- **DATA.** After bit 7, go to PARITY or STOP.
- **STOP.** Drive `TxD`=1. At its end:
  - if the FIFO is non-empty, pop and drive `TxD`=0 on the same edge, entering START with no idle gap;
  - otherwise go to IDLE and set `TxBUSY`=0.
- **`TIC` and `TxSTB` in the same cycle while IDLE and empty.** The byte is not yet visible to the FSM; it starts on the following `TIC`.
- **Outside `TIC` cycles**, the FSM, `tcnt` and `TxD` hold their values.

## Timing
- **Latency.** A write into an idle, empty transmitter drives `TxD` low on the first `TIC` edge strictly after the write edge.
- **Frame length.**
  - 80 `TIC`s (10 bits) without parity.
  - 88 `TIC`s with parity.
- **Back-to-back bytes.** Frames are contiguous on the line.
- **Throughput.** One byte per frame time. The host may burst up to `FIFO_DEPTH` bytes at one per clock while IDLE. The first is popped on the next `TIC`, so a burst of `FIFO_DEPTH`+1 can be accepted only if a `TIC` intervenes.
- **Flags.** `TxFULL` and `TxEMPTY` are registered and reflect the count after the current edge.
- **`TxOVF`.** Always exactly one clock wide.

## Configuration
- **`DEV_UART_TX_PARITY_EN` defined:**
  - a PARITY state is inserted between DATA and STOP, lasting 8 `TIC`s;
  - `TxD` = XOR of the 8 data bits (even parity);
  - frame is 11 bits.
- **Undefined:** there is no PARITY state and no parity logic; frame is 10 bits (8N1).

## Test plan
- **Reset then single byte.** Hold `RST` for 3 clocks, `TIC` every 8 clocks, write 0xA5 → `TxD` low on the next `TIC` edge. Sampled mid-bit, `TxD` is 0,1,0,1,0,0,1,0,1,1 with 8 `TIC`s per bit. `TxBUSY` falls after the stop bit, and `dev_uart_rx` looped back strobes `RxQ`=0xA5.
- **Burst.** Write 0x00,0xFF,0x55,0x0F on consecutive clocks, FIFO_DEPTH=4 →
  - `TxFULL`=1 after the 4th write;
  - four contiguous 80-`TIC` frames with no idle high between stop and start;
  - `TxEMPTY`=1 after the last pop.
- **Overflow.** With the FIFO full, issue a 5th `TxSTB` 0x77 → `TxOVF` pulses for 1 clock, 0x77 is never transmitted, and the count stays 4.
- **Simultaneous push/pop.** With the FIFO full, assert `TxSTB` on the clock of a stop-bit-end `TIC` → the write is dropped (`TxOVF`=1) and the count becomes 3. Repeat with count 3: both happen and the count stays 3.
- **Reset mid-frame.** Assert `RST` during bit 4 of 0x3C with 2 bytes queued → `TxD`=1 next edge, `TxBUSY`=0, `TxEMPTY`=1; nothing is sent after release until a new write.
- **Parity build.** With `DEV_UART_TX_PARITY_EN` defined, send 0x07 → parity bit 1 and an 88-`TIC` frame. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/dev_uart_tx.sv
// 8N1 UART transmitter with a small byte FIFO, paced by an 8x-baud TIC strobe.
// Even parity bit between data and stop is compiled in with DEV_UART_TX_PARITY_EN.
module dev_uart_tx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TIC,
  input  logic [7:0] TxDAT,
  input  logic       TxSTB,
  output logic       TxD,
  output logic       TxFULL,
  output logic       TxEMPTY,
  output logic       TxBUSY,
  output logic       TxOVF
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef DEV_UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;

  logic [2:0]    r_state;
  logic [2:0]    r_tcnt;
  logic [2:0]    r_bidx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_busy;
`ifdef DEV_UART_TX_PARITY_EN
  logic          r_par;
`endif

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_cnt_nxt;

  // Acceptance looks only at the registered full flag, so a pop in the same
  // cycle never rescues a write into a full FIFO.
  assign w_push = TxSTB && !r_full;
  assign w_pop  = TIC && !r_empty &&
                  ((r_state == S_IDLE) || ((r_state == S_STOP) && (r_tcnt == 3'd0)));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + CW'(1);
    else if (!w_push && w_pop)
      w_cnt_nxt = r_cnt - CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (w_push)
      r_mem[r_wptr] <= TxDAT;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == CW'(FIFO_DEPTH));
      r_empty <= (w_cnt_nxt == '0);
      r_ovf   <= TxSTB && r_full;
    end
  end

  // tcnt counts down the 8 TICs of the current bit; state moves only when it hits 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_tcnt  <= 3'd0;
      r_bidx  <= 3'd0;
      r_shift <= 8'd0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
`ifdef DEV_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (TIC) begin
      if ((r_state != S_IDLE) && (r_tcnt != 3'd0)) begin
        r_tcnt <= r_tcnt - 3'd1;
      end else begin
        case (r_state)
          S_IDLE, S_STOP: begin
            if (w_pop) begin
              r_shift <= r_mem[r_rptr];
`ifdef DEV_UART_TX_PARITY_EN
              r_par   <= ^r_mem[r_rptr];
`endif
              r_txd   <= 1'b0;
              r_tcnt  <= 3'd7;
              r_state <= S_START;
              r_busy  <= 1'b1;
            end else begin
              r_txd   <= 1'b1;
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
          S_START: begin
            r_txd   <= r_shift[0];
            r_bidx  <= 3'd0;
            r_tcnt  <= 3'd7;
            r_state <= S_DATA;
          end
          S_DATA: begin
            r_tcnt <= 3'd7;
            if (r_bidx == 3'd7) begin
`ifdef DEV_UART_TX_PARITY_EN
              r_txd   <= r_par;
              r_state <= S_PARITY;
`else
              r_txd   <= 1'b1;
              r_state <= S_STOP;
`endif
            end else begin
              r_shift <= r_shift >> 1;
              r_txd   <= r_shift[1];
              r_bidx  <= r_bidx + 3'd1;
            end
          end
`ifdef DEV_UART_TX_PARITY_EN
          S_PARITY: begin
            r_txd   <= 1'b1;
            r_tcnt  <= 3'd7;
            r_state <= S_STOP;
          end
`endif
          default: begin
            r_txd   <= 1'b1;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign TxD     = r_txd;
  assign TxFULL  = r_full;
  assign TxEMPTY = r_empty;
  assign TxBUSY  = r_busy;
  assign TxOVF   = r_ovf;

endmodule

// File: tb/tb_dev_uart_tx.sv
// Directed bench for dev_uart_tx: reset, single byte, burst/overflow,
// simultaneous push/pop, reset mid-frame, and parity frames when built with it.
module tb_dev_uart_tx;

  logic       CLK   = 1'b0;
  logic       RST   = 1'b1;
  logic       TIC   = 1'b0;
  logic [7:0] TxDAT = 8'd0;
  logic       TxSTB = 1'b0;
  logic       TxD;
  logic       TxFULL;
  logic       TxEMPTY;
  logic       TxBUSY;
  logic       TxOVF;

  int n_vec = 0;
  int n_err = 0;

`ifdef DEV_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  dev_uart_tx #(.FIFO_DEPTH(4)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .TIC     (TIC),
    .TxDAT   (TxDAT),
    .TxSTB   (TxSTB),
    .TxD     (TxD),
    .TxFULL  (TxFULL),
    .TxEMPTY (TxEMPTY),
    .TxBUSY  (TxBUSY),
    .TxOVF   (TxOVF)
  );

  always #5 CLK = ~CLK;

  // TIC high for one clock in every eight, changed just after the edge.
  initial begin
    forever begin
      repeat (7) begin
        @(posedge CLK);
        #1 TIC = 1'b0;
      end
      @(posedge CLK);
      #1 TIC = 1'b1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next clock edge that samples TIC high.
  task automatic tic_edge();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      @(posedge CLK);
      seen = TIC;
    end
    #2;
    if (!seen) check("tic_timeout", 32'd0, 32'd1);
  endtask

  task automatic write_byte(input logic [7:0] d);
    TxSTB = 1'b1;
    TxDAT = d;
    @(posedge CLK);
    #2;
    TxSTB = 1'b0;
  endtask

  // Strobe a byte so that it is sampled on the next TIC edge.
  task automatic stb_on_tic(input logic [7:0] d);
    for (int i = 0; i < 16 && !TIC; i++) begin
      @(posedge CLK);
      #2;
    end
    write_byte(d);
  endtask

  // Called just after the start-bit edge; returns just after the stop-bit end edge.
  task automatic frame(input string name, input logic [7:0] b, input bit more,
                       input bit inj, input logic [7:0] idat);
    logic [10:0] e;
`ifdef DEV_UART_TX_PARITY_EN
    e = {1'b1, ^b, b, 1'b0};
`else
    e = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int k = 0; k < NB; k++) begin
      repeat (4) tic_edge();
      check($sformatf("%s_bit%0d", name, k), 32'(TxD), 32'(e[k]));
      if (k < NB - 1) repeat (4) tic_edge();
    end
    repeat (3) tic_edge();
    check($sformatf("%s_busy_stop", name), 32'(TxBUSY), 32'd1);
    if (inj) stb_on_tic(idat);
    else tic_edge();
    check($sformatf("%s_end_txd", name), 32'(TxD), more ? 32'd0 : 32'd1);
    check($sformatf("%s_end_busy", name), 32'(TxBUSY), more ? 32'd1 : 32'd0);
  endtask

  initial begin
    // Reset held for three clocks
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    check("rst_txd",   32'(TxD),     32'd1);
    check("rst_busy",  32'(TxBUSY),  32'd0);
    check("rst_full",  32'(TxFULL),  32'd0);
    check("rst_empty", 32'(TxEMPTY), 32'd1);
    check("rst_ovf",   32'(TxOVF),   32'd0);
    RST = 1'b0;

    // Single byte 0xA5
    tic_edge();
    write_byte(8'hA5);
    check("a5_empty_after_wr", 32'(TxEMPTY), 32'd0);
    tic_edge();
    check("a5_latency_txd", 32'(TxD),     32'd0);
    check("a5_latency_busy", 32'(TxBUSY), 32'd1);
    check("a5_popped_empty", 32'(TxEMPTY), 32'd1);
    frame("a5", 8'hA5, 1'b0, 1'b0, 8'h00);

    // Burst of four, then an overflow write
    tic_edge();
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h55);
    write_byte(8'h0F);
    check("burst_full",  32'(TxFULL),  32'd1);
    check("burst_empty", 32'(TxEMPTY), 32'd0);
    write_byte(8'h77);
    check("ovf_pulse", 32'(TxOVF),  32'd1);
    check("ovf_full",  32'(TxFULL), 32'd1);
    @(posedge CLK);
    #2;
    check("ovf_one_clock", 32'(TxOVF), 32'd0);
    tic_edge();
    check("burst_start_txd", 32'(TxD),    32'd0);
    check("burst_pop_full",  32'(TxFULL), 32'd0);
    frame("b00", 8'h00, 1'b1, 1'b0, 8'h00);
    frame("bff", 8'hFF, 1'b1, 1'b0, 8'h00);
    frame("b55", 8'h55, 1'b1, 1'b0, 8'h00);
    check("burst_last_pop_empty", 32'(TxEMPTY), 32'd1);
    frame("b0f", 8'h0F, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tic_edge();
      check("no_77_sent", {30'd0, TxD, TxBUSY}, 32'h2);
    end

    // Simultaneous push/pop: full -> dropped, then count 3 -> both happen
    tic_edge();
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    write_byte(8'h44);
    tic_edge();
    check("sim_start_txd", 32'(TxD), 32'd0);
    write_byte(8'h55);
    check("sim_full_again", 32'(TxFULL), 32'd1);
    frame("s11", 8'h11, 1'b1, 1'b1, 8'h66);
    check("sim_full_drop_ovf", 32'(TxOVF),  32'd1);
    check("sim_full_drop_cnt", 32'(TxFULL), 32'd0);
    frame("s22", 8'h22, 1'b1, 1'b1, 8'h77);
    check("sim_cnt3_no_ovf", 32'(TxOVF),  32'd0);
    check("sim_cnt3_full",   32'(TxFULL), 32'd0);
    write_byte(8'h88);
    check("sim_cnt_was_3", 32'(TxFULL), 32'd1);
    frame("s33", 8'h33, 1'b1, 1'b0, 8'h00);
    frame("s44", 8'h44, 1'b1, 1'b0, 8'h00);
    frame("s55", 8'h55, 1'b1, 1'b0, 8'h00);
    frame("s77", 8'h77, 1'b1, 1'b0, 8'h00);
    check("sim_drained", 32'(TxEMPTY), 32'd1);
    frame("s88", 8'h88, 1'b0, 1'b0, 8'h00);

    // Reset during bit 4 of 0x3C with two bytes queued
    tic_edge();
    write_byte(8'h3C);
    write_byte(8'hA1);
    write_byte(8'hB2);
    tic_edge();
    check("mr_start_txd", 32'(TxD), 32'd0);
    repeat (44) tic_edge();
    check("mr_bit4", 32'(TxD), 32'd1);
    RST = 1'b1;
    @(posedge CLK);
    #2;
    check("mr_txd",   32'(TxD),     32'd1);
    check("mr_busy",  32'(TxBUSY),  32'd0);
    check("mr_empty", 32'(TxEMPTY), 32'd1);
    check("mr_full",  32'(TxFULL),  32'd0);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tic_edge();
      check("mr_stays_idle", {30'd0, TxD, TxBUSY}, 32'h2);
    end
    write_byte(8'h5A);
    tic_edge();
    check("mr_resume_txd", 32'(TxD), 32'd0);
    frame("r5a", 8'h5A, 1'b0, 1'b0, 8'h00);

`ifdef DEV_UART_TX_PARITY_EN
    tic_edge();
    write_byte(8'h07);
    tic_edge();
    check("p07_start", 32'(TxD), 32'd0);
    frame("p07", 8'h07, 1'b0, 1'b0, 8'h00);
    tic_edge();
    write_byte(8'h03);
    tic_edge();
    check("p03_start", 32'(TxD), 32'd0);
    frame("p03", 8'h03, 1'b0, 1'b0, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
